key_debouncer: RTL

KEY_DEBOUNCER -- requirements
Module: key_debouncer

---
 rtl/gobang_input_pkg.sv | 23 ++
 rtl/key_fsm.sv | 160 ++++++++++++++++
 rtl/key_debouncer.sv | 74 +++++++
 3 files changed

// File: rtl/gobang_input_pkg.sv
// -----------------------------------------------------------------------------
// gobang_input_pkg
// Shared definitions for the push-button input block of the gobang board:
//   - key_state_e : per-key debounce FSM state encoding
//   - KEY_*       : bit index of each button inside the key vectors
// No ports (package).
// -----------------------------------------------------------------------------
package gobang_input_pkg;

    typedef enum logic [1:0] {
        KS_RELEASED    = 2'd0,
        KS_PRESS_CHK   = 2'd1,
        KS_PRESSED     = 2'd2,
        KS_RELEASE_CHK = 2'd3
    } key_state_e;

    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;
    localparam int KEY_OK    = 4;

endpackage

// File: rtl/key_fsm.sv
// -----------------------------------------------------------------------------
// key_fsm
// Debounce and auto-repeat state machine for a single push button. All state
// moves only on sample ticks; outputs are registered.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   tick_i    in   one-clk sample strobe shared by all keys
//   raw_i     in   synchronized button level, 1 = pressed
//   level_o   out  debounced level (1 in PRESSED / RELEASE_CHK)
//   press_o   out  one-clk pulse on accepted press and on each auto-repeat
//   release_o out  one-clk pulse on accepted release
// -----------------------------------------------------------------------------
module key_fsm
    import gobang_input_pkg::*;
#(
    parameter int STABLE_CNT   = 4,
    parameter int REPEAT_DELAY = 32,
    parameter int REPEAT_RATE  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_i,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int CW      = $clog2(STABLE_CNT + 1);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW      = $clog2(REP_MAX + 1);

    localparam logic [CW-1:0] STAB_TERM  = CW'(STABLE_CNT);
    localparam logic [RW-1:0] DELAY_TERM = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RATE_TERM  = RW'(REPEAT_RATE);

    key_state_e    state_q;
    logic [CW-1:0] stab_q;
    logic [RW-1:0] rep_q;
    // Set once the first (delayed) repeat has fired; afterwards the repeat
    // counter measures REPEAT_RATE intervals instead of REPEAT_DELAY.
    logic          rep_arm_q;
    logic          level_q;
    logic          press_q;
    logic          release_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= KS_RELEASED;
            stab_q    <= '0;
            rep_q     <= '0;
            rep_arm_q <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            if (tick_i) begin
                case (state_q)
                    KS_RELEASED: begin
                        if (raw_i) begin
                            // A single-sample stability requirement accepts
                            // the very first tick at the new level.
                            if (STABLE_CNT == 1) begin
                                state_q   <= KS_PRESSED;
                                level_q   <= 1'b1;
                                press_q   <= 1'b1;
                                rep_q     <= '0;
                                rep_arm_q <= 1'b0;
                            end else begin
                                state_q <= KS_PRESS_CHK;
                                stab_q  <= CW'(1);
                            end
                        end
                    end
                    KS_PRESS_CHK: begin
                        if (raw_i) begin
                            if (stab_q + CW'(1) == STAB_TERM) begin
                                state_q   <= KS_PRESSED;
                                stab_q    <= '0;
                                level_q   <= 1'b1;
                                press_q   <= 1'b1;
                                rep_q     <= '0;
                                rep_arm_q <= 1'b0;
                            end else begin
                                stab_q <= stab_q + CW'(1);
                            end
                        end else begin
                            state_q <= KS_RELEASED;
                            stab_q  <= '0;
                        end
                    end
                    KS_PRESSED: begin
                        if (!raw_i) begin
                            rep_q     <= '0;
                            rep_arm_q <= 1'b0;
                            if (STABLE_CNT == 1) begin
                                state_q   <= KS_RELEASED;
                                level_q   <= 1'b0;
                                release_q <= 1'b1;
                            end else begin
                                state_q <= KS_RELEASE_CHK;
                                stab_q  <= CW'(1);
                            end
                        end else if (REPEAT_DELAY > 0) begin
                            // Counter reloads to 0 at each terminal value, so
                            // it never wraps while the key is held.
                            if (!rep_arm_q) begin
                                if (rep_q + RW'(1) == DELAY_TERM) begin
                                    press_q   <= 1'b1;
                                    rep_q     <= '0;
                                    rep_arm_q <= 1'b1;
                                end else begin
                                    rep_q <= rep_q + RW'(1);
                                end
                            end else begin
                                if (rep_q + RW'(1) == RATE_TERM) begin
                                    press_q <= 1'b1;
                                    rep_q   <= '0;
                                end else begin
                                    rep_q <= rep_q + RW'(1);
                                end
                            end
                        end
                    end
                    KS_RELEASE_CHK: begin
                        if (!raw_i) begin
                            if (stab_q + CW'(1) == STAB_TERM) begin
                                state_q   <= KS_RELEASED;
                                stab_q    <= '0;
                                level_q   <= 1'b0;
                                release_q <= 1'b1;
                            end else begin
                                stab_q <= stab_q + CW'(1);
                            end
                        end else begin
                            // Bounce back to held: repeat timing restarts.
                            state_q   <= KS_PRESSED;
                            stab_q    <= '0;
                            rep_q     <= '0;
                            rep_arm_q <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= KS_RELEASED;
                        stab_q  <= '0;
                        level_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/key_debouncer.sv
// -----------------------------------------------------------------------------
// key_debouncer
// Debounces NUM_KEYS push buttons sampled at a rate derived from one bit of
// the system clock divider, with optional auto-repeat on held keys.
// Ports:
//   clk         in   system clock (same clock as the divider)
//   rst         in   synchronous active-high reset
//   tick_src    in   divider count bit; each rising edge is one sample tick
//   key_raw     in   [NUM_KEYS] asynchronous button levels, 1 = pressed
//   key_level   out  [NUM_KEYS] debounced level per key
//   key_press   out  [NUM_KEYS] one-clk pulse on press and on auto-repeat
//   key_release out  [NUM_KEYS] one-clk pulse on release
// -----------------------------------------------------------------------------
module key_debouncer
    import gobang_input_pkg::*;
#(
    parameter int NUM_KEYS     = 5,
    parameter int STABLE_CNT   = 4,
    parameter int REPEAT_DELAY = 32,
    parameter int REPEAT_RATE  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tick_src,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    logic                tick_meta_q;
    logic                tick_sync_q;
    logic                tick_prev_q;
    logic [NUM_KEYS-1:0] key_meta_q;
    logic [NUM_KEYS-1:0] key_sync_q;
    logic                tick;

    // Tick and keys share the same two-flop depth, so a key level applied
    // together with a tick_src rise is the value seen on that tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_meta_q <= 1'b0;
            tick_sync_q <= 1'b0;
            tick_prev_q <= 1'b0;
            key_meta_q  <= '0;
            key_sync_q  <= '0;
        end else begin
            tick_meta_q <= tick_src;
            tick_sync_q <= tick_meta_q;
            tick_prev_q <= tick_sync_q;
            key_meta_q  <= key_raw;
            key_sync_q  <= key_meta_q;
        end
    end

    assign tick = tick_sync_q & ~tick_prev_q;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_fsm #(
            .STABLE_CNT   (STABLE_CNT),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_key_fsm (
            .clk       (clk),
            .rst       (rst),
            .tick_i    (tick),
            .raw_i     (key_sync_q[g]),
            .level_o   (key_level[g]),
            .press_o   (key_press[g]),
            .release_o (key_release[g])
        );
    end

endmodule
